riscv_trace_buffer: RTL



---
 rtl/riscv_trace_pkg.sv | 32 +++
 rtl/riscv_trace_buffer_fifo.sv | 51 +++++
 rtl/riscv_trace_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the riscv commit-trace capture stage.
package riscv_trace_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int HDR_W      = 12;
    localparam int REC_DATA_W = 32;

    typedef enum logic [1:0] {
        KIND_REG   = 2'b01,
        KIND_STORE = 2'b10,
        KIND_LOAD  = 2'b11
    } trace_kind_e;

    // Record header; the data field follows it in the low DATA_W bits.
    typedef struct packed {
        logic        ovf;
        trace_kind_e kind;
        logic [8:0]  index;
    } trace_hdr_t;

    typedef struct packed {
        trace_hdr_t              hdr;
        logic [REC_DATA_W-1:0]   data;
    } trace_rec_t;

    function automatic int trace_w(input int data_w);
        return data_w + HDR_W;
    endfunction

    localparam int TRACE_W = trace_w(REC_DATA_W);

endpackage

// File: rtl/riscv_trace_buffer_fifo.sv
// Two-write-port, one-read-port circular FIFO; port 1 is only written together with port 0.
module trace_fifo_2w1r #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0,
    input  logic [WIDTH-1:0]         data0,
    input  logic                     push1,
    input  logic [WIDTH-1:0]         data1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_nxt1;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       n_push;

    assign wr_ptr_nxt1 = wr_ptr + AW'(1);
    assign n_push      = {1'b0, push0} + {1'b0, push1};

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= data0;
        if (push1) mem[wr_ptr_nxt1] <= data1;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + LW'(n_push) - LW'(pop);
        end
    end

    assign valid = (level != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: decodes writeback/memory events into records, buffers them, tracks drops.
// Optional feature macro: TRACE_MEM_READ_EN (records LOAD events from rd/rd_data).
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     reg_write_sig,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [DATA_W+11:0]       trace_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              dropped_count
);

    localparam int TW = trace_w(DATA_W);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] ALMOST_LVL = LW'(DEPTH - 1);

    logic                   ev_a;
    logic                   ev_b;
    trace_hdr_t             hdr_a;
    trace_hdr_t             hdr_b;
    logic [DATA_W-1:0]      data_b;
    logic [TW-1:0]          rec_a;
    logic [TW-1:0]          rec_b;
    logic [TW-1:0]          first_rec;
    logic [TW-1:0]          wdata0;
    logic [TW-1:0]          wdata1;
    logic [1:0]             n_ev;
    logic [1:0]             n_push;
    logic [1:0]             n_drop;
    logic                   push0;
    logic                   push1;
    logic                   pop;
    logic                   ovf_pending;
    logic [DROP_CNT_W-1:0]  drop_cnt;
    logic [DROP_CNT_W:0]    drop_sum;

    always_comb begin
        ev_a   = trace_en && reg_write_sig && (reg_num != 5'd0);
        hdr_a  = '{ovf: 1'b0, kind: KIND_REG, index: {4'b0000, reg_num}};
        hdr_b  = '{ovf: 1'b0, kind: KIND_STORE, index: addr};
        data_b = wr_data;
        ev_b   = trace_en && wr;
`ifdef TRACE_MEM_READ_EN
        if (trace_en && rd && !wr) begin
            ev_b       = 1'b1;
            hdr_b.kind = KIND_LOAD;
            data_b     = rd_data;
        end
`endif
        rec_a = {hdr_a, reg_data};
        rec_b = {hdr_b, data_b};
    end

`ifndef TRACE_MEM_READ_EN
    logic unused_rd;
    assign unused_rd = ^{rd, rd_data};
`endif

    // Space is judged on the registered level only; a same-cycle pop frees nothing.
    always_comb begin
        n_ev = {1'b0, ev_a} + {1'b0, ev_b};
        if (fifo_level == FULL_LVL) begin
            n_push = 2'd0;
        end else if ((fifo_level == ALMOST_LVL) && (n_ev == 2'd2)) begin
            n_push = 2'd1;
        end else begin
            n_push = n_ev;
        end
        n_drop    = n_ev - n_push;
        push0     = (n_push != 2'd0);
        push1     = (n_push == 2'd2);
        first_rec = ev_a ? rec_a : rec_b;
        wdata0    = {ovf_pending, first_rec[TW-2:0]};
        wdata1    = rec_b;
        drop_sum  = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'(n_drop);
    end

    assign pop = trace_valid && trace_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_pending <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (n_drop != 2'd0) begin
                ovf_pending <= 1'b1;
            end else if (push0) begin
                ovf_pending <= 1'b0;
            end
            drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign dropped_count = drop_cnt;

    trace_fifo_2w1r #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .data0 (wdata0),
        .push1 (push1),
        .data1 (wdata1),
        .pop   (pop),
        .head  (trace_data),
        .valid (trace_valid),
        .level (fifo_level)
    );

endmodule
